// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (issue FSM states, default baud divider).
package uart_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DRAIN = 2'd3} tx_state_e;
  localparam int BAUD_DIV = 27_000_000 / 115_200;
endpackage

// File: rtl/uart_tx_fifo_mem.sv
// uart_tx_fifo_mem: DEPTH x 8 storage, synchronous write, asynchronous read.
module uart_tx_fifo_mem #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter over a ready/strobe handshake.
// Define UART_TX_FIFO_OVERFLOW_EN to add a sticky overflow output and a drop counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] level,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_start
`ifdef UART_TX_FIFO_OVERFLOW_EN
  , output logic          overflow
`endif
);
  logic [ADDR_W:0] wr_ptr_q, rd_ptr_q;
  logic [7:0] tx_data_q, tx_data_d, rd_data;
  logic tx_start_q, tx_start_d, push, pop;
  tx_state_e state_q, state_d;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign push = wr_en && !full;
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  uart_tx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );
  // S_DRAIN seeing ready behaves exactly like S_IDLE so bytes go back to back
  always_comb begin
    pop = (state_q == S_IDLE || state_q == S_DRAIN) && tx_ready && !empty;
    tx_start_d = pop;
    tx_data_d = pop ? rd_data : tx_data_q;
    state_d = pop ? S_ISSUE :
              state_q == S_ISSUE ? S_WAIT :
              (state_q == S_WAIT && !tx_ready) ? S_DRAIN :
              (state_q == S_DRAIN && tx_ready) ? S_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_q + {{ADDR_W{1'b0}}, push};
      rd_ptr_q <= rd_ptr_q + {{ADDR_W{1'b0}}, pop};
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      state_q <= state_d;
    end
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q;
  logic [7:0] drop_cnt_q;
  assign overflow = overflow_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (wr_en && full) begin
      overflow_q <= 1'b1;
      drop_cnt_q <= drop_cnt_q + {7'd0, drop_cnt_q != 8'hFF};
    end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a behavioural transmitter.
module tb_uart_tx_fifo;
  localparam int WAIT_CYCLES = 10;
  localparam int BUSY = 10 * WAIT_CYCLES;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, d_ready = 1'b0, model_on = 1'b0, m_ready = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, tx_start, tx_ready;
  logic [4:0] level;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow;
`endif
  int total = 0, bad = 0, cyc = 0;
  logic [1:0] m_st = 2'd0;
  int m_cnt = 0, cap_n = 0;
  logic [7:0] cap_d [4];
  int cap_c [4];
  assign tx_ready = model_on ? m_ready : d_ready;
  uart_tx_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .tx_ready(tx_ready), .tx_data(tx_data), .tx_start(tx_start)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // transmitter: ready one cycle, sample strobe next cycle, then BUSY cycles of frame
  always @(posedge clk)
    if (!model_on) begin
      m_st <= 2'd0; m_ready <= 1'b0; m_cnt <= 0; cap_n <= 0;
    end else case (m_st)
      2'd0: begin m_ready <= 1'b1; m_st <= 2'd1; end
      2'd1: begin m_ready <= 1'b0; m_st <= 2'd2; end
      2'd2: if (tx_start) begin
              if (cap_n < 4) begin cap_d[cap_n] <= tx_data; cap_c[cap_n] <= cyc; end
              cap_n <= cap_n + 1; m_cnt <= BUSY - 1; m_st <= 2'd3;
            end else begin m_ready <= 1'b1; m_st <= 2'd1; end
      default: if (m_cnt == 0) begin m_ready <= 1'b1; m_st <= 2'd1; end else m_cnt <= m_cnt - 1;
    endcase
  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
`ifdef UART_TX_FIFO_OVERFLOW_EN
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_idle;
    logic seen = 1'b0;
    model_on = 1'b1;
    repeat (40) begin @(negedge clk); if (tx_start) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%b exp=0", seen); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL idle_empty got=%b exp=1", empty); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL idle_level got=%0d exp=0", level); end
    model_on = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single;
    push(8'h55);
    total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level1 got=%0d exp=1", level); end
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", tx_start); end
    total++; if (tx_data !== 8'h55) begin bad++; $display("FAIL single_data got=%h exp=55", tx_data); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL single_level0 got=%0d exp=0", level); end
    @(negedge clk);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_low got=%b exp=0", tx_start); end
    total++; if (tx_data !== 8'h55) begin bad++; $display("FAIL single_hold got=%h exp=55", tx_data); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int n = 0;
    model_on = 1'b1;
    @(negedge clk);
    push(8'hA1); push(8'hB2); push(8'hC3);
    while (cap_n < 3 && n < 1000) begin @(negedge clk); n++; end
    total++; if (n >= 1000) begin bad++; $display("FAIL b2b_timeout got=%0d exp=3", cap_n); end
    repeat (BUSY + 20) @(negedge clk);
    total++; if (cap_n !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", cap_n); end
    total++; if (cap_d[0] !== 8'hA1) begin bad++; $display("FAIL b2b_byte0 got=%h exp=a1", cap_d[0]); end
    total++; if (cap_d[1] !== 8'hB2) begin bad++; $display("FAIL b2b_byte1 got=%h exp=b2", cap_d[1]); end
    total++; if (cap_d[2] !== 8'hC3) begin bad++; $display("FAIL b2b_byte2 got=%h exp=c3", cap_d[2]); end
    total++; if (cap_c[1] - cap_c[0] !== BUSY + 2) begin bad++; $display("FAIL b2b_gap01 got=%0d exp=%0d", cap_c[1] - cap_c[0], BUSY + 2); end
    total++; if (cap_c[2] - cap_c[1] !== BUSY + 2) begin bad++; $display("FAIL b2b_gap12 got=%0d exp=%0d", cap_c[2] - cap_c[1], BUSY + 2); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    model_on = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_full;
    for (int i = 0; i < 15; i++) push(i[7:0]);
    total++; if (full !== 1'b0) begin bad++; $display("FAIL full_at15 got=%b exp=0", full); end
    push(8'd15);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_at16 got=%b exp=1", full); end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
    push(8'd16);
    total++; if (level !== 5'd16) begin bad++; $display("FAIL full_drop_level got=%0d exp=16", level); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_drop_full got=%b exp=1", full); end
`ifdef UART_TX_FIFO_OVERFLOW_EN
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", overflow); end
    total++; if (dut.drop_cnt_q !== 8'd1) begin bad++; $display("FAIL full_drop_cnt got=%0d exp=1", dut.drop_cnt_q); end
`endif
  endtask
  task automatic test_wrap;
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    total++; if (tx_data !== 8'd0) begin bad++; $display("FAIL wrap_first got=%0d exp=0", tx_data); end
    total++; if (level !== 5'd15) begin bad++; $display("FAIL wrap_level15 got=%0d exp=15", level); end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      d_ready = 1'b1; wr_en = 1'b1; wr_data = 8'(16 + k);
      @(negedge clk);
      d_ready = 1'b0; wr_en = 1'b0;
      total++; if (tx_data !== 8'(k + 1)) begin bad++; $display("FAIL wrap_pp_data got=%0d exp=%0d", tx_data, k + 1); end
      total++; if (level !== 5'd15) begin bad++; $display("FAIL wrap_pp_level got=%0d exp=15", level); end
      repeat (2) @(negedge clk);
    end
    for (int k = 0; k < 15; k++) begin
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
      total++; if (tx_data !== 8'(17 + k)) begin bad++; $display("FAIL wrap_drain got=%0d exp=%0d", tx_data, 17 + k); end
      repeat (2) @(negedge clk);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask
  task automatic test_reset_mid;
    push(8'h11); push(8'h22);
    d_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (level !== 5'd1) begin bad++; $display("FAIL mid_level_pre got=%0d exp=1", level); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b exp=0", tx_start); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", level); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data got=%h exp=00", tx_data); end
    d_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h7E);
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL mid_new_start got=%b exp=1", tx_start); end
    total++; if (tx_data !== 8'h7E) begin bad++; $display("FAIL mid_new_data got=%h exp=7e", tx_data); end
    @(negedge clk);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_new_low got=%b exp=0", tx_start); end
  endtask
  initial begin
    test_reset;
    test_idle;
    test_single;
    test_back_to_back;
    test_full;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
